// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg: shared types and constants for the instruction fetch controller.
//   state_t          : fetch FSM state encoding
//   RESET_PC_DEFAULT : default first fetch address after reset
//   INSTR_W          : instruction and address width
//   NOP              : value of an empty instruction register
package fetch_controller_pkg;
   typedef enum logic [1:0] {ST_START, ST_FETCH, ST_DISCARD, ST_HOLD} state_t;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/fetch_controller_skid_buffer.sv
// fetch_skid_buffer: one-entry holding register for a fetched instruction and its PC.
//   i_clk/i_reset : clock, asynchronous active-high reset
//   i_load        : capture i_instr/i_pc and mark the entry valid
//   i_clear       : drop the entry (wins over i_load)
//   o_valid/o_instr/o_pc : stored entry
module fetch_skid_buffer
   import fetch_controller_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_load,
   input  logic               i_clear,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [INSTR_W-1:0] i_pc,
   output logic               o_valid,
   output logic [INSTR_W-1:0] o_instr,
   output logic [INSTR_W-1:0] o_pc
);
   logic               r_valid;
   logic [INSTR_W-1:0] r_instr;
   logic [INSTR_W-1:0] r_pc;
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_valid <= 1'b0;
         r_instr <= NOP;
         r_pc    <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end
   end
   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: single-outstanding instruction fetch unit with skid buffer and redirect handling.
//   i_clk/i_reset            : clock, asynchronous active-high reset
//   o_mem_req/o_mem_address  : fetch request and word-aligned address
//   i_mem_ready/i_mem_instruction : memory response strobe and data
//   i_stall                  : downstream cannot accept, output registers hold
//   i_redirect/i_redirect_pc : flush and refetch from the given target
//   o_if_valid/o_if_instruction/o_if_pc/o_if_pc_plus4 : fetched instruction outputs
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               i_clk,
   input  logic               i_reset,
   output logic               o_mem_req,
   output logic [31:0]        o_mem_address,
   input  logic               i_mem_ready,
   input  logic [INSTR_W-1:0] i_mem_instruction,
   input  logic               i_stall,
   input  logic               i_redirect,
   input  logic [31:0]        i_redirect_pc,
   output logic               o_if_valid,
   output logic [INSTR_W-1:0] o_if_instruction,
   output logic [31:0]        o_if_pc,
   output logic [31:0]        o_if_pc_plus4
);
   state_t             r_state;
   state_t             w_next_state;
   logic [31:0]        r_pc;
   logic [31:0]        r_discard_addr;
   logic               r_if_valid;
   logic [INSTR_W-1:0] r_if_instruction;
   logic [31:0]        r_if_pc;
   logic               w_redirect;
   logic               w_accept;
   logic               w_to_out;
   logic               w_to_skid;
   logic               w_unskid;
   logic               w_skid_valid;
   logic [INSTR_W-1:0] w_skid_instr;
   logic [31:0]        w_skid_pc;
   // Redirect is ignored during the single START cycle.
   assign w_redirect = i_redirect && (r_state != ST_START);
   assign w_accept   = (r_state == ST_FETCH) && i_mem_ready && !i_redirect;
   assign w_to_out   = w_accept && (!r_if_valid || !i_stall);
   assign w_to_skid  = w_accept && r_if_valid && i_stall;
   assign w_unskid   = (r_state == ST_HOLD) && !i_stall && !i_redirect;
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= ST_START;
      else         r_state <= w_next_state;
   end
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_START:   w_next_state = ST_FETCH;
         ST_FETCH:   w_next_state = i_redirect ? (i_mem_ready ? ST_FETCH : ST_DISCARD)
                                   : w_to_skid ? ST_HOLD : ST_FETCH;
         ST_DISCARD: w_next_state = i_mem_ready ? ST_FETCH : ST_DISCARD;
         ST_HOLD:    w_next_state = (i_redirect || !i_stall) ? ST_FETCH : ST_HOLD;
         default:    w_next_state = ST_START;
      endcase
   end
   // While discarding, the abandoned request keeps its address even though the PC already moved.
   always_comb begin
      o_mem_req     = (r_state == ST_FETCH) || (r_state == ST_DISCARD);
      o_mem_address = (r_state == ST_DISCARD) ? r_discard_addr : r_pc;
   end
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pc           <= RESET_PC;
         r_discard_addr <= '0;
      end else begin
         if (w_redirect)    r_pc <= i_redirect_pc & ~32'd3;
         else if (w_accept) r_pc <= r_pc + 32'd4;
         if ((r_state == ST_FETCH) && i_redirect && !i_mem_ready) r_discard_addr <= r_pc;
      end
   end
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_if_valid       <= 1'b0;
         r_if_instruction <= NOP;
         r_if_pc          <= '0;
      end else if (w_redirect) begin
         r_if_valid <= 1'b0;
      end else if (w_to_out) begin
         r_if_valid       <= 1'b1;
         r_if_instruction <= i_mem_instruction;
         r_if_pc          <= r_pc;
      end else if (w_unskid) begin
         r_if_valid       <= 1'b1;
         r_if_instruction <= w_skid_instr;
         r_if_pc          <= w_skid_pc;
      end else if (!i_stall) begin
         r_if_valid <= 1'b0;
      end
   end
   fetch_skid_buffer u_skid (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (w_to_skid),
      .i_clear (w_redirect || w_unskid),
      .i_instr (i_mem_instruction),
      .i_pc    (r_pc),
      .o_valid (w_skid_valid),
      .o_instr (w_skid_instr),
      .o_pc    (w_skid_pc)
   );
   assign o_if_valid       = r_if_valid;
   assign o_if_instruction = r_if_instruction;
   assign o_if_pc          = r_if_pc;
   assign o_if_pc_plus4    = r_if_pc + 32'd4;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: randomized and directed checks of fetch_controller against a transaction-level model.
module tb_fetch_controller;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req, mem_ready, stall, redirect, if_valid;
   logic [31:0] mem_address, mem_instruction, redirect_pc, if_instruction, if_pc, if_pc_plus4;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_instr, w_pc, w_p4;
   int n_vec = 0;
   int n_err = 0;
   typedef struct {logic [31:0] instr; logic [31:0] pc;} ent_t;
   bit          m_started, m_valid, m_drop;
   logic [31:0] m_pc, m_old, m_instr, m_ifpc;
   ent_t        m_skid[$];
   always #5 clk = ~clk;
   fetch_controller u_dut (
      .i_clk(clk), .i_reset(rst), .o_mem_req(mem_req), .o_mem_address(mem_address),
      .i_mem_ready(mem_ready), .i_mem_instruction(mem_instruction), .i_stall(stall),
      .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_if_valid(if_valid),
      .o_if_instruction(if_instruction), .o_if_pc(if_pc), .o_if_pc_plus4(if_pc_plus4)
   );
   fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .i_clk(clk), .i_reset(rst), .o_mem_req(w_req), .o_mem_address(w_addr),
      .i_mem_ready(1'b1), .i_mem_instruction(32'h1234_5678), .i_stall(1'b0),
      .i_redirect(1'b0), .i_redirect_pc(32'h0), .o_if_valid(w_valid),
      .o_if_instruction(w_instr), .o_if_pc(w_pc), .o_if_pc_plus4(w_p4)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_started = 0; m_valid = 0; m_drop = 0;
      m_pc = 32'h0; m_old = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0;
      m_skid.delete();
   endtask
   // A request is outstanding whenever fetching has started and no instruction waits in the skid.
   function automatic bit exp_req();
      return m_started && (m_skid.size() == 0);
   endfunction
   task automatic compare();
      check("mem_req", {31'b0, mem_req}, {31'b0, exp_req()});
      if (exp_req()) check("mem_address", mem_address, m_drop ? m_old : m_pc);
      check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      check("if_instruction", if_instruction, m_instr);
      check("if_pc", if_pc, m_ifpc);
      check("if_pc_plus4", if_pc_plus4, m_ifpc + 32'd4);
   endtask
   task automatic model_step(input bit rdy, input bit stl, input bit rdr, input logic [31:0] rpc,
                             input logic [31:0] ins);
      bit req;
      req = exp_req();
      if (!m_started) begin
         m_started = 1;
      end else if (rdr) begin
         if (req && !rdy) begin
            if (!m_drop) m_old = m_pc;
            m_drop = 1;
         end else m_drop = 0;
         m_pc = {rpc[31:2], 2'b00};
         m_valid = 0;
         m_skid.delete();
      end else if (m_drop) begin
         if (rdy) m_drop = 0;
      end else if (m_skid.size() != 0) begin
         if (!stl) begin
            m_instr = m_skid[0].instr; m_ifpc = m_skid[0].pc; m_valid = 1;
            m_skid.delete();
         end
      end else if (rdy) begin
         if (!m_valid || !stl) begin
            m_instr = ins; m_ifpc = m_pc; m_valid = 1;
         end else m_skid.push_back('{ins, m_pc});
         m_pc = m_pc + 32'd4;
      end else if (m_valid && !stl) m_valid = 0;
   endtask
   task automatic step(input bit rdy, input bit stl, input bit rdr, input logic [31:0] rpc);
      compare();
      mem_ready = rdy; stall = stl; redirect = rdr; redirect_pc = rpc;
      mem_instruction = $urandom;
      @(posedge clk);
      model_step(rdy, stl, rdr, rpc, mem_instruction);
      #1;
   endtask
   initial begin
      rst = 1; mem_ready = 0; stall = 0; redirect = 0; redirect_pc = 0; mem_instruction = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_req", {31'b0, mem_req}, 32'd0);
      check("reset_valid", {31'b0, if_valid}, 32'd0);
      check("reset_if_pc", if_pc, 32'd0);
      rst = 0;
      step(1, 0, 0, 0);
      check("first_addr", mem_address, 32'h0);
      step(1, 0, 0, 0);
      check("wrap_pc_a", w_pc, 32'hFFFF_FFFC);
      check("wrap_p4_a", w_p4, 32'h0);
      step(1, 0, 0, 0);
      check("wrap_pc_b", w_pc, 32'h0);
      check("wrap_p4_b", w_p4, 32'h4);
      check("stream_addr8", mem_address, 32'h8);
      step(1, 1, 0, 0);
      check("hold_req", {31'b0, mem_req}, 32'd0);
      step(0, 0, 0, 0);
      check("unskid_pc", if_pc, 32'h8);
      check("after_hold_addr", mem_address, 32'hC);
      step(0, 0, 1, 32'h40);
      step(0, 0, 0, 0);
      step(0, 0, 1, 32'h80);
      check("discard_addr_held", mem_address, 32'hC);
      step(1, 0, 0, 0);
      check("after_discard_addr", mem_address, 32'h80);
      step(1, 0, 0, 0);
      step(1, 1, 1, 32'h43);
      check("redirect_valid", {31'b0, if_valid}, 32'd0);
      check("redirect_addr", mem_address, 32'h40);
      step(0, 0, 0, 0);
      #3 rst = 1;
      #1;
      check("async_req", {31'b0, mem_req}, 32'd0);
      check("async_valid", {31'b0, if_valid}, 32'd0);
      mem_ready = 1;
      @(posedge clk);
      #1 rst = 0;
      model_reset();
      step(1, 0, 0, 0);
      check("rst_addr", mem_address, 32'h0);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom);
      compare();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
